mem_arbiter: RTL

- Shares the single-port calculator memory between two requesters: port 0 is the calculator controller and port 1 is the host loader/debug reader.
- Performs round-robin arbitration, with an optional lock that gives one requester bounded burst ownership.
- Tracks fixed-latency read returns and routes `rvalid` back to the requester that issued the read.
- Sits between the requesters and the memory macro; replaces the direct controller-to-memory connection.

---
 rtl/calculator_pkg.sv | 8 +
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/calculator_pkg.sv
// Shared calculator definitions: memory geometry used by the blocks that
// talk to the single-port calculator memory.
package calculator_pkg;

   localparam int ADDR_W        = 8;
   localparam int MEM_WORD_SIZE = 64;

endpackage : calculator_pkg

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port calculator memory.
// Port 0 is the calculator controller, port 1 the host loader/debug reader.
// Grants are round-robin. A port may lock the grant for bounded bursts.
// Read returns are tracked through a fixed-latency pipe and steered back
// to the port that issued them.
module mem_arbiter #(
   parameter int ADDR_W        = calculator_pkg::ADDR_W,
   parameter int MEM_WORD_SIZE = calculator_pkg::MEM_WORD_SIZE,
   parameter int RD_LAT        = 1,
   parameter int MAX_BURST     = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [1:0]               req_i,
   input  logic [1:0]               we_i,
   input  logic [1:0]               lock_i,
   input  logic [ADDR_W-1:0]        addr0_i,
   input  logic [ADDR_W-1:0]        addr1_i,
   input  logic [MEM_WORD_SIZE-1:0] wdata0_i,
   input  logic [MEM_WORD_SIZE-1:0] wdata1_i,
   output logic [1:0]               gnt_o,
   output logic [1:0]               rvalid_o,
   output logic [MEM_WORD_SIZE-1:0] rdata_o,
   output logic                     mem_read,
   output logic                     mem_write,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [MEM_WORD_SIZE-1:0] mem_wdata,
   input  logic [MEM_WORD_SIZE-1:0] mem_rdata
);

   localparam int               CNT_W     = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] BURST_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OWN0 = 2'd1,
      S_OWN1 = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             last_gnt_q, last_gnt_d;   // index of the most recently granted port
   logic [CNT_W-1:0] burst_q, burst_d;         // consecutive grants in the current ownership

   logic gnt_v;   // a grant is issued this cycle
   logic gnt_p;   // index of the granted port
   logic keep;    // grant is a locked continuation of the current owner
   logic own;     // current owner index (meaningful in S_OWN0/S_OWN1)
   logic other;

   logic [RD_LAT-1:0] rd_valid_q;
   logic [RD_LAT-1:0] rd_id_q;

   // Arbitration: pick this cycle's grant and derive the next ownership state
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // one unassigned; an unassigned path would infer a latch.
      state_d    = state_q;
      burst_d    = burst_q;
      last_gnt_d = last_gnt_q;
      gnt_v      = 1'b0;
      gnt_p      = 1'b0;
      keep       = 1'b0;
      own        = (state_q == S_OWN1);
      other      = ~own;

      case (state_q)
         S_IDLE: begin
            if (req_i[0] && req_i[1]) begin
               gnt_v = 1'b1;
               gnt_p = ~last_gnt_q;
            end else if (req_i[0]) begin
               gnt_v = 1'b1;
               gnt_p = 1'b0;
            end else if (req_i[1]) begin
               gnt_v = 1'b1;
               gnt_p = 1'b1;
            end
         end
         S_OWN0, S_OWN1: begin
            if (req_i[own] && lock_i[own] && ((burst_q < BURST_MAX) || !req_i[other])) begin
               gnt_v = 1'b1;
               gnt_p = own;
               keep  = 1'b1;
            end else if (req_i[other]) begin
               gnt_v = 1'b1;
               gnt_p = other;
            end else if (req_i[own]) begin
               gnt_v = 1'b1;
               gnt_p = own;
            end
         end
         default: ;
      endcase

      // Nothing is granted while reset is asserted
      if (rst_i) begin
         gnt_v = 1'b0;
      end

      if (gnt_v) begin
         state_d    = gnt_p ? S_OWN1 : S_OWN0;
         last_gnt_d = gnt_p;
         if (keep) begin
            burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + BURST_ONE;
         end else begin
            burst_d = BURST_ONE;
         end
      end else begin
         state_d = S_IDLE;
         burst_d = '0;
      end
   end

   // Command path: forward the granted port's request to the memory
   always_comb begin
      gnt_o     = {gnt_v & gnt_p, gnt_v & ~gnt_p};
      mem_write = gnt_v & (gnt_p ? we_i[1] : we_i[0]);
      mem_read  = gnt_v & ~(gnt_p ? we_i[1] : we_i[0]);
      mem_addr  = gnt_v ? (gnt_p ? addr1_i : addr0_i) : '0;
      mem_wdata = gnt_v ? (gnt_p ? wdata1_i : wdata0_i) : '0;
   end

   // Ownership state, round-robin pointer and burst counter
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples values from before the edge, regardless of statement order.
      if (rst_i) begin
         state_q    <= S_IDLE;
         last_gnt_q <= 1'b1;
         burst_q    <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         burst_q    <= burst_d;
      end
   end

   // Read-return pipe: {valid, port id} shifted RD_LAT stages behind the read
   always_ff @(posedge clk_i) begin
      // NOTE: this pipe is reset even though it looks like a data delay line;
      // a stale valid bit surviving reset would raise rvalid for a dead read.
      if (rst_i) begin
         rd_valid_q <= '0;
         rd_id_q    <= '0;
      end else begin
         rd_valid_q[0] <= mem_read;
         rd_id_q[0]    <= gnt_p;
         for (int i = 1; i < RD_LAT; i++) begin
            rd_valid_q[i] <= rd_valid_q[i-1];
            rd_id_q[i]    <= rd_id_q[i-1];
         end
      end
   end

   // Steer the returning read to its issuer; data is shared by both ports
   always_comb begin
      rvalid_o = '0;
      if (!rst_i && rd_valid_q[RD_LAT-1]) begin
         rvalid_o[rd_id_q[RD_LAT-1]] = 1'b1;
      end
      rdata_o = mem_rdata;
   end

endmodule : mem_arbiter
